// File: rtl/qmax_table_rmw.sv
// rtl/qmax_table_rmw.sv - per-state Q-max store with read-modify-write max-update pipeline
module qmax_table_rmw #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 65536,
    parameter bit                    FLOAT      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    output logic                  o_ready,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_upd_en,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [DATA_WIDTH-1:0] i_upd_data,
    input  logic                  i_upd_mode,
    output logic                  o_upd_done,
    output logic                  o_upd_chg,
    output logic [DATA_WIDTH-1:0] o_upd_data
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic [DATA_WIDTH-1:0] rd_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] upd_mem [DEPTH];

    logic                  rd_acc;
    logic                  upd_acc;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_cand;
    logic                  s1_mode;
    logic [DATA_WIDTH-1:0] s1_mem_old;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] s1_old;
    logic [DATA_WIDTH-1:0] s1_new;
    logic                  s1_commit;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // True when a is strictly greater than b; ties keep the stored value.
    function automatic logic q_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (FLOAT) begin
            if (ma == '0 && mb == '0)
                q_gt = 1'b0;
            else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
                q_gt = !a[DATA_WIDTH-1];
            else if (!a[DATA_WIDTH-1])
                q_gt = ma > mb;
            else
                q_gt = ma < mb;
        end else begin
            q_gt = $signed(a) > $signed(b);
        end
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= ST_CLEAR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (!i_clr && clr_cnt == LAST_ADDR) state_nxt = ST_RUN;
            ST_RUN:   if (i_clr) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    assign o_ready = (state == ST_RUN);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr || state == ST_RUN)
            clr_cnt <= '0;
        else
            clr_cnt <= clr_cnt + 1'b1;
    end

    assign rd_acc  = o_ready && i_rd_en;
    assign upd_acc = o_ready && i_upd_en && !i_clr;

    // S1 sees the previous S1 result through the bypass, since its write lands at our read edge.
    assign s1_old    = fwd_hit ? fwd_data : s1_mem_old;
    assign s1_new    = (s1_mode && !q_gt(s1_cand, s1_old)) ? s1_old : s1_cand;
    assign s1_commit = s1_valid && !i_clr;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_addr;
        wr_data = s1_new;
        if (state == ST_CLEAR) begin
            wr_en   = i_rst_n;
            wr_addr = clr_cnt;
            wr_data = INIT_VAL;
        end else if (s1_commit) begin
            wr_en   = i_rst_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            rd_mem[wr_addr]  <= wr_data;
            upd_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= rd_acc;
            if (rd_acc)
                o_rd_data <= rd_mem[i_rd_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            fwd_hit    <= 1'b0;
            o_upd_done <= 1'b0;
            o_upd_chg  <= 1'b0;
            o_upd_data <= '0;
        end else begin
            s1_valid   <= upd_acc;
            fwd_hit    <= upd_acc && s1_commit && (s1_addr == i_upd_addr);
            o_upd_done <= s1_commit;
            o_upd_chg  <= s1_commit && (s1_new != s1_old);
            if (s1_commit)
                o_upd_data <= s1_new;
        end
    end

    always_ff @(posedge i_clk) begin
        if (upd_acc) begin
            s1_addr    <= i_upd_addr;
            s1_cand    <= i_upd_data;
            s1_mode    <= i_upd_mode;
            s1_mem_old <= upd_mem[i_upd_addr];
        end
        if (s1_commit)
            fwd_data <= s1_new;
    end

endmodule

// File: tb/tb_qmax_table_rmw.sv
// tb/tb_qmax_table_rmw.sv - directed self-checking bench for qmax_table_rmw
module tb_qmax_table_rmw;

    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          DEPTH = 12;
    localparam logic [31:0] INIT  = 32'h3E80_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          upd_en = 1'b0;
    logic [AW-1:0] upd_addr = '0;
    logic [DW-1:0] upd_data = '0;
    logic          upd_mode = 1'b0;

    logic          ready_f, rd_valid_f, upd_done_f, upd_chg_f;
    logic [DW-1:0] rd_data_f, upd_data_f;
    logic          ready_i, rd_valid_i, upd_done_i, upd_chg_i;
    logic [DW-1:0] rd_data_i, upd_data_i;

    qmax_table_rmw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FLOAT(1'b1), .INIT_VAL(INIT)) dut_f (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_ready(ready_f),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data_f), .o_rd_valid(rd_valid_f),
        .i_upd_en(upd_en), .i_upd_addr(upd_addr), .i_upd_data(upd_data), .i_upd_mode(upd_mode),
        .o_upd_done(upd_done_f), .o_upd_chg(upd_chg_f), .o_upd_data(upd_data_f)
    );

    qmax_table_rmw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FLOAT(1'b0), .INIT_VAL(INIT)) dut_i (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .o_ready(ready_i),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data_i), .o_rd_valid(rd_valid_i),
        .i_upd_en(upd_en), .i_upd_addr(upd_addr), .i_upd_data(upd_data), .i_upd_mode(upd_mode),
        .o_upd_done(upd_done_i), .o_upd_chg(upd_chg_i), .o_upd_data(upd_data_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          chg;
    } res_t;

    typedef struct {
        logic [DW-1:0] old_v;
        logic [DW-1:0] cand;
        logic [DW-1:0] exp_f;
        logic          chg_f;
        logic [DW-1:0] exp_i;
        logic          chg_i;
    } vec_t;

    int            n_chk = 0;
    int            n_fail = 0;
    res_t          q_f[$];
    res_t          q_i[$];
    logic [DW-1:0] q_rd[$];
    vec_t          vecs[10];

    always @(negedge clk) begin
        if (upd_done_f) q_f.push_back({upd_data_f, upd_chg_f});
        if (upd_done_i) q_i.push_back({upd_data_i, upd_chg_i});
        if (rd_valid_f) q_rd.push_back(rd_data_f);
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic re, input logic [AW-1:0] ra,
                        input logic ue, input logic [AW-1:0] ua, input logic [DW-1:0] ud, input logic um);
        clr = c; rd_en = re; rd_addr = ra;
        upd_en = ue; upd_addr = ua; upd_data = ud; upd_mode = um;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic flush();
        q_f.delete(); q_i.delete(); q_rd.delete();
    endtask

    task automatic expect_upd(input string name, input bit is_int, input logic [DW-1:0] exp_d, input logic exp_c);
        res_t r;
        bit   have;
        have = is_int ? (q_i.size() > 0) : (q_f.size() > 0);
        n_chk++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: no update response, expected data 0x%0h chg %0d", name, exp_d, exp_c);
        end else begin
            if (is_int) r = q_i.pop_front();
            else        r = q_f.pop_front();
            check({name, ".data"}, r.data, exp_d);
            check({name, ".chg"}, 32'(r.chg), 32'(exp_c));
        end
    endtask

    task automatic expect_rd(input string name, input logic [DW-1:0] exp_d);
        logic [DW-1:0] d;
        n_chk++;
        if (q_rd.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no read response, expected 0x%0h", name, exp_d);
        end else begin
            d = q_rd.pop_front();
            check(name, d, exp_d);
        end
    endtask

    // Counts falling edges until o_ready is seen high, bounded.
    task automatic count_ready(input string name);
        int c;
        c = 0;
        while (!ready_f && c < DEPTH + 20) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(c), 32'(DEPTH));
        check({name, ".int_copy"}, 32'(ready_i), 32'd1);
    endtask

    task automatic read_one(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
        flush();
        step(1'b0, 1'b1, a, 1'b0, '0, '0, 1'b0);
        idle(2);
        expect_rd(name, exp_d);
    endtask

    initial begin
        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b1, 32'h4000_0000, 1'b1};
        vecs[1] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0};
        vecs[2] = '{32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0};
        vecs[6] = '{32'hC000_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b1, 32'h3F00_0000, 1'b1};
        vecs[7] = '{32'h7F7F_FFFF, 32'h0000_0001, 32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF, 1'b0};
        vecs[8] = '{32'hBF80_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'hBF80_0000, 1'b0};
        vecs[9] = '{32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b1, 32'hC000_0000, 1'b0};

        // Reset with requests asserted: everything must stay quiet.
        rst_n = 1'b0;
        step(1'b0, 1'b1, 4'd2, 1'b1, 4'd2, 32'h4000_0000, 1'b0);
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(ready_f), 32'd0);
        check("rst.rd_valid", 32'(rd_valid_f), 32'd0);
        check("rst.upd_done", 32'(upd_done_f), 32'd0);
        check("rst.upd_chg", 32'(upd_chg_f), 32'd0);
        check("rst.rd_data", rd_data_f, 32'd0);
        check("rst.upd_data", upd_data_f, 32'd0);
        flush();
        rst_n = 1'b1;
        count_ready("sweep_after_reset");
        idle(3);
        check("no_pulse_during_sweep", 32'(q_f.size() + q_i.size() + q_rd.size()), 32'd0);

        flush();
        for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, AW'(a), 1'b0, '0, '0, 1'b0);
        idle(2);
        for (int a = 0; a < DEPTH; a++) expect_rd($sformatf("init_rd[%0d]", a), INIT);

        // Back-to-back max updates on one address exercise the forwarding path.
        flush();
        step(1'b0, 1'b0, '0, 1'b1, 4'd5, 32'h3F80_0000, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 4'd5, 32'h3F00_0000, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 4'd5, 32'h4000_0000, 1'b1);
        idle(3);
        for (int d = 0; d < 2; d++) begin
            expect_upd($sformatf("fwd%0d.u0", d), d[0], 32'h3F80_0000, 1'b1);
            expect_upd($sformatf("fwd%0d.u1", d), d[0], 32'h3F80_0000, 1'b0);
            expect_upd($sformatf("fwd%0d.u2", d), d[0], 32'h4000_0000, 1'b1);
        end

        // Read-first at the commit edge; new value visible one cycle after commit.
        flush();
        step(1'b0, 1'b1, 4'd9, 1'b1, 4'd9, 32'h4040_0000, 1'b0);
        check("rf.valid_lat1", 32'(rd_valid_f), 32'd1);
        check("rf.accept_edge", rd_data_f, INIT);
        step(1'b0, 1'b1, 4'd9, 1'b0, '0, '0, 1'b0);
        check("rf.commit_edge", rd_data_f, INIT);
        step(1'b0, 1'b1, 4'd9, 1'b0, '0, '0, 1'b0);
        check("rf.after_commit", rd_data_f, 32'h4040_0000);
        idle(1);
        check("rf.valid_pulse", 32'(rd_valid_f), 32'd0);
        expect_upd("rf.upd", 1'b0, 32'h4040_0000, 1'b1);

        // Overwrite mode, including an overwrite with the same value.
        flush();
        step(1'b0, 1'b0, '0, 1'b1, 4'd3, 32'h4000_0000, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 4'd3, 32'h3F00_0000, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 4'd3, 32'h3F00_0000, 1'b0);
        idle(3);
        expect_upd("ovw.u0", 1'b0, 32'h4000_0000, 1'b1);
        expect_upd("ovw.u1", 1'b0, 32'h3F00_0000, 1'b1);
        expect_upd("ovw.u2", 1'b0, 32'h3F00_0000, 1'b0);
        read_one("ovw.rd", 4'd3, 32'h3F00_0000);

        // Ordering table: overwrite old, then max-update with the candidate, back to back.
        for (int i = 0; i < 10; i++) begin
            flush();
            step(1'b0, 1'b0, '0, 1'b1, AW'(i), vecs[i].old_v, 1'b0);
            step(1'b0, 1'b0, '0, 1'b1, AW'(i), vecs[i].cand, 1'b1);
            idle(3);
            expect_upd($sformatf("vec%0d.f.old", i), 1'b0, vecs[i].old_v, vecs[i].old_v != INIT);
            expect_upd($sformatf("vec%0d.f", i), 1'b0, vecs[i].exp_f, vecs[i].chg_f);
            expect_upd($sformatf("vec%0d.i.old", i), 1'b1, vecs[i].old_v, vecs[i].old_v != INIT);
            expect_upd($sformatf("vec%0d.i", i), 1'b1, vecs[i].exp_i, vecs[i].chg_i);
        end

        // Clear while an update sits in S1: the update is dropped.
        flush();
        step(1'b0, 1'b0, '0, 1'b1, 4'd10, 32'h40A0_0000, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        check("clr.ready_low", 32'(ready_f), 32'd0);
        clr = 1'b0; rd_en = 1'b1; rd_addr = 4'd10; upd_en = 1'b1; upd_addr = 4'd10;
        count_ready("sweep_after_clr");
        idle(3);
        check("clr.no_pulses", 32'(q_f.size() + q_i.size() + q_rd.size()), 32'd0);
        read_one("clr.rd10", 4'd10, INIT);
        read_one("clr.rd5", 4'd5, INIT);

        // Clear during a sweep restarts it at address 0.
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        idle(5);
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        clr = 1'b0;
        count_ready("sweep_restart_clr");

        // Reset in the middle of a sweep restarts it too.
        step(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        idle(4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_ready("sweep_restart_rst");
        read_one("rst.rd3", 4'd3, INIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
